// File: rtl/fetch_controller_pkg.sv
// Shared constants for the instruction-fetch stage: data width, reset PC
// and the fetch FSM state encodings.
package fetch_controller_pkg;

    localparam int          WORD_SIZE = 16;
    localparam logic [15:0] RESET_PC  = 16'h0000;

    typedef logic [2:0] state_t;

    localparam state_t ST_RESET_WAIT = 3'd0;
    localparam state_t ST_REQ        = 3'd1;
    localparam state_t ST_HOLD       = 3'd2;
    localparam state_t ST_SQUASH     = 3'd3;
    localparam state_t ST_DMA_WAIT   = 3'd4;

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-stage bundle: ID-stage control, predictor links, instruction memory
// bus and the DMA handshake. master = fetch controller side.
interface fetch_controller_if #(
    parameter int WIDTH = fetch_controller_pkg::WORD_SIZE
) ();

    logic             stall;
    logic             prediction_miss;
    logic [WIDTH-1:0] pred_next_addr;
    logic             bus_grant_dma;
    logic             i_ready;
    logic [WIDTH-1:0] i_data;

    logic             i_readM;
    logic [WIDTH-1:0] i_address;
    logic [WIDTH-1:0] inst_addr;
    logic [WIDTH-1:0] next_addr_seq;
    logic             bp_stall;
    logic             cpu_bus_busy;
    logic [WIDTH-1:0] IF_ID_inst;
    logic [WIDTH-1:0] IF_ID_pc;
    logic             ID_nop;

    modport master (
        input  stall, prediction_miss, pred_next_addr, bus_grant_dma, i_ready, i_data,
        output i_readM, i_address, inst_addr, next_addr_seq, bp_stall, cpu_bus_busy,
               IF_ID_inst, IF_ID_pc, ID_nop
    );

    modport slave (
        output stall, prediction_miss, pred_next_addr, bus_grant_dma, i_ready, i_data,
        input  i_readM, i_address, inst_addr, next_addr_seq, bp_stall, cpu_bus_busy,
               IF_ID_inst, IF_ID_pc, ID_nop
    );

endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues reads at PC, parks for DMA, keeps one
// word across ID stalls and squashes an in-flight read on a predictor redirect.
module fetch_controller #(
    parameter int                   WORD_SIZE = fetch_controller_pkg::WORD_SIZE,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = fetch_controller_pkg::RESET_PC
) (
    input logic                clk,
    input logic                reset_n,
    fetch_controller_if.master bus
);

    import fetch_controller_pkg::state_t;
    import fetch_controller_pkg::ST_RESET_WAIT;
    import fetch_controller_pkg::ST_REQ;
    import fetch_controller_pkg::ST_HOLD;
    import fetch_controller_pkg::ST_SQUASH;
    import fetch_controller_pkg::ST_DMA_WAIT;

    localparam logic [WORD_SIZE-1:0] PC_STEP = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WORD_SIZE-1:0] pc_r;
    logic [WORD_SIZE-1:0] squash_addr_r;
    logic [WORD_SIZE-1:0] hold_inst_r;
    logic                 outstanding_r;
    logic [WORD_SIZE-1:0] id_inst_r;
    logic [WORD_SIZE-1:0] id_pc_r;
    logic                 id_nop_r;
    logic                 read_s;
    logic                 accept_s;
    logic                 load_hold_s;
    logic [WORD_SIZE-1:0] addr_s;

    // Read request: a started read is never abandoned, so DMA only wins in REQ when nothing is in flight
    always_comb begin
        read_s = 1'b0;
        case (state_r)
            ST_REQ:    read_s = outstanding_r | ~bus.bus_grant_dma;
            ST_SQUASH: read_s = 1'b1;
            default:   read_s = 1'b0;
        endcase
    end

    // A squashed read keeps presenting its original address until acknowledged
    always_comb begin
        if (state_r == ST_SQUASH) begin
            addr_s = squash_addr_r;
        end else begin
            addr_s = pc_r;
        end
    end

    // Next state, ID acceptance and buffer load; a redirect overrides every other event
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        load_hold_s = 1'b0;
        if (bus.prediction_miss) begin
            if (read_s && !bus.i_ready) begin
                state_nxt_s = ST_SQUASH;
            end else begin
                state_nxt_s = ST_REQ;
            end
        end else begin
            case (state_r)
                ST_RESET_WAIT: begin
                    state_nxt_s = bus.bus_grant_dma ? ST_DMA_WAIT : ST_REQ;
                end
                ST_REQ: begin
                    if (!read_s) begin
                        state_nxt_s = ST_DMA_WAIT;
                    end else if (bus.i_ready && bus.stall) begin
                        state_nxt_s = ST_HOLD;
                        load_hold_s = 1'b1;
                    end else if (bus.i_ready) begin
                        accept_s    = 1'b1;
                    end else begin
                        state_nxt_s = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (!bus.stall) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ST_REQ;
                    end else begin
                        state_nxt_s = ST_HOLD;
                    end
                end
                ST_SQUASH: begin
                    state_nxt_s = bus.i_ready ? ST_REQ : ST_SQUASH;
                end
                ST_DMA_WAIT: begin
                    state_nxt_s = bus.bus_grant_dma ? ST_DMA_WAIT : ST_REQ;
                end
                default: begin
                    state_nxt_s = ST_RESET_WAIT;
                end
            endcase
        end
    end

    // FSM, PC, squash address, stall buffer and in-flight tracking
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r       <= ST_RESET_WAIT;
            pc_r          <= RESET_PC;
            squash_addr_r <= {WORD_SIZE{1'b0}};
            hold_inst_r   <= {WORD_SIZE{1'b0}};
            outstanding_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            outstanding_r <= read_s & ~bus.i_ready;
            if (bus.prediction_miss || accept_s) begin
                pc_r <= bus.pred_next_addr;
            end
            if (bus.prediction_miss) begin
                squash_addr_r <= addr_s;
            end
            if (load_hold_s) begin
                hold_inst_r <= bus.i_data;
            end
        end
    end

    // IF/ID pipeline register; a bubble is inserted whenever ID is free but nothing is delivered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            id_inst_r <= {WORD_SIZE{1'b0}};
            id_pc_r   <= {WORD_SIZE{1'b0}};
            id_nop_r  <= 1'b1;
        end else if (bus.prediction_miss) begin
            id_nop_r  <= 1'b1;
        end else if (accept_s) begin
            id_inst_r <= (state_r == ST_HOLD) ? hold_inst_r : bus.i_data;
            id_pc_r   <= pc_r;
            id_nop_r  <= 1'b0;
        end else if (!bus.stall) begin
            id_nop_r  <= 1'b1;
        end
    end

    assign bus.i_readM       = read_s;
    assign bus.i_address     = addr_s;
    assign bus.inst_addr     = pc_r;
    assign bus.next_addr_seq = pc_r + PC_STEP;
    assign bus.bp_stall      = ~(accept_s | bus.prediction_miss);
    assign bus.cpu_bus_busy  = read_s;
    assign bus.IF_ID_inst    = id_inst_r;
    assign bus.IF_ID_pc      = id_pc_r;
    assign bus.ID_nop        = id_nop_r;

endmodule
